mem_ctrl: RTL
=============

// Module: mem_ctrl
// PURPOSE
//  Memory-side responder for the instruction cache fetch port and the data load/store port.
//  Turns each 32-bit request into sequential byte accesses on the single byte-wide RAM bus.
//  Reads are assembled little-endian; the requester gets a one-cycle completion pulse.
//  Sits between inst_cache / the MEM stage and the external RAM. One transaction in flight at a time.
// PARAMETERS
//  ADDR_W         32  address width of all address ports
//  DATA_PRIORITY  1   1: data request wins same-cycle arbitration vs. fetch; 0: fetch wins
// PORTS
//  clk             in   1       clock, all state updates on rising edge
//  rst             in   1       asynchronous, active-high reset
//  inst_needed     in   1       fetch request, held high until inst_available
//  addr_to_mem     in   ADDR_W  fetch address, byte address
//  inst_available  out  1       one-cycle pulse: inst_from_mem valid this cycle
//  inst_from_mem   out  32      fetched instruction word
//  data_needed     in   1       load/store request, held high until data_available
//  data_we         in   1       1 = store, 0 = load
//  data_len        in   2       00 = byte, 01 = half, 11 = word (10 treated as word)
//  data_addr       in   ADDR_W  load/store byte address
//  data_wdata      in   32      store data, low data_len bytes used
//  data_available  out  1       one-cycle pulse: store done / data_rdata valid
//  data_rdata      out  32      load result, zero-extended (caller sign-extends)
//  mem_din         in   8       RAM read byte, valid 1 cycle after mem_a issued
//  mem_dout        out  8       RAM write byte
//  mem_a           out  ADDR_W  RAM byte address
//  mem_wr          out  1       1 = write mem_dout to mem_a this cycle
// BEHAVIOUR
//  - Reset (async): every output 0, state IDLE, byte counter 0, latched address/data cleared.
//  - States: IDLE, INST_RD, DATA_RD, DATA_WR, DONE. All outputs registered.
//  - IDLE: request sampled at edge ending cycle t. Both pending -> DATA_PRIORITY picks.
//    Base address, len and wdata are latched. N = 1/2/4 bytes.
//  - RD: mem_a = base+k in cycles t+1..t+N, mem_wr = 0.
//    Byte k is captured from mem_din in cycle t+2+k into bits [8k+7:8k].
//    Result and available pulse in cycle t+N+2: fetch in t+6, lb in t+3.
//  - WR: mem_wr = 1, mem_a = base+k, mem_dout = wdata[8k+7:8k] in cycles t+1..t+N.
//    data_available in cycle t+N+1: sw in t+5.
//  - DONE: the available pulse cycle. Requests in this cycle are ignored, because requester deassert lags by one cycle.
//    Next accept is no earlier than cycle after the pulse.
//  - IDLE/DONE: mem_a = 0, mem_wr = 0, mem_dout = 0.
//  - inst_from_mem/data_rdata hold their value after the pulse until the next completion of the same port.
//  - Fetch abort: inst_needed low during INST_RD -> IDLE at next edge, no inst_available.
//  - Fetch redirect: addr_to_mem != latched base during INST_RD -> restart fetch from new address at k=0.
//  - Data requests are never aborted. A store in progress always completes all N bytes.
//  - Address arithmetic base+k wraps modulo 2^ADDR_W.
//  - Losing request stays pending and is accepted in the first IDLE cycle.
//  - rst mid-transaction: mem_wr drops immediately (async), no available pulse, partial write is not undone.
// TESTING
//  1. Word fetch: RAM[0x1000..0x1003] = 13 05 00 00, inst_needed@t
//     -> mem_a 0x1000..0x1003 in t+1..t+4; inst_available, inst_from_mem = 0x00000513 at t+6 only.
//  2. sw 0xDEADBEEF to 0x2000
//     -> mem_wr = 1 for t+1..t+4; mem_dout EF,BE,AD,DE; data_available at t+5; RAM readback matches.
//  3. inst_needed and data_needed (lw 0x3000) same cycle, DATA_PRIORITY = 1
//     -> data_available at t+6, then fetch accepted t+7, inst_available at t+13.
//  4. lb 0x2001 with RAM byte 0x80
//     -> data_rdata = 0x00000080 at t+3. lh 0x2000 -> {RAM[0x2001], RAM[0x2000]} zero-extended.
//  5. inst_needed dropped at t+2 of fetch -> no inst_available; new fetch at t+4 completes at t+10.
//     addr_to_mem changed at t+2 -> mem_a restarts at the new address.
//  6. rst asserted mid-store after 2 bytes -> mem_wr, mem_a and outputs 0 the same cycle.
//     After release, a lw completes normally.

Source files
------------

// File: rtl/mem_ctrl.sv
// Byte-serial RAM responder for the instruction fetch port and the data load/store port.
// One 32-bit transaction at a time, split into 1/2/4 sequential byte accesses, little-endian.
module mem_ctrl #(
    parameter int unsigned ADDR_W        = 32,
    parameter bit          DATA_PRIORITY = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_needed,
    input  logic [ADDR_W-1:0] addr_to_mem,
    output logic              inst_available,
    output logic [31:0]       inst_from_mem,
    input  logic              data_needed,
    input  logic              data_we,
    input  logic [1:0]        data_len,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_available,
    output logic [31:0]       data_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);

    typedef enum logic [2:0] {StIdle, StInstRd, StDataRd, StDataWr, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [1:0]        last_q, last_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              issue_q, issue_d;
    logic              cap_q, cap_d;
    logic [1:0]        cap_idx_q, cap_idx_d;
    logic [31:0]       buf_q, buf_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic              mem_wr_q, mem_wr_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              inst_av_q, inst_av_d;
    logic [31:0]       inst_q, inst_d;
    logic              data_av_q, data_av_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              sel_data;
    logic [1:0]        nxt;
    logic [ADDR_W-1:0] next_a;
    logic [1:0]        len_last;
    logic [31:0]       merged;

    assign sel_data = data_needed && (DATA_PRIORITY || !inst_needed);
    assign nxt      = cnt_q + 2'd1;
    assign next_a   = base_q + ADDR_W'(nxt);
    assign len_last = (data_len == 2'b00) ? 2'd0 : (data_len == 2'b01) ? 2'd1 : 2'd3;

    // Assembled word with the byte arriving this cycle merged in.
    always_comb begin
        merged = buf_q;
        merged[{cap_idx_q, 3'b000} +: 8] = mem_din;
    end

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        last_d     = last_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        issue_d    = issue_q;
        cap_d      = cap_q;
        cap_idx_d  = cap_idx_q;
        buf_d      = buf_q;
        mem_a_d    = '0;
        mem_wr_d   = 1'b0;
        mem_dout_d = '0;
        inst_av_d  = 1'b0;
        inst_d     = inst_q;
        data_av_d  = 1'b0;
        rdata_d    = rdata_q;

        unique case (state_q)
            StIdle: begin
                cnt_d   = '0;
                cap_d   = 1'b0;
                buf_d   = '0;
                if (sel_data) begin
                    base_d  = data_addr;
                    last_d  = len_last;
                    wdata_d = data_wdata;
                    mem_a_d = data_addr;
                    if (data_we) begin
                        state_d    = StDataWr;
                        mem_wr_d   = 1'b1;
                        mem_dout_d = data_wdata[7:0];
                    end else begin
                        state_d = StDataRd;
                        issue_d = 1'b1;
                    end
                end else if (inst_needed) begin
                    state_d = StInstRd;
                    base_d  = addr_to_mem;
                    last_d  = 2'd3;
                    mem_a_d = addr_to_mem;
                    issue_d = 1'b1;
                end
            end
            StInstRd, StDataRd: begin
                if (state_q == StInstRd && !inst_needed) begin
                    state_d = StIdle;
                    issue_d = 1'b0;
                    cap_d   = 1'b0;
                end else if (state_q == StInstRd && addr_to_mem != base_q) begin
                    // Redirect: bytes still in flight belong to the old address and are dropped.
                    base_d  = addr_to_mem;
                    mem_a_d = addr_to_mem;
                    cnt_d   = '0;
                    issue_d = 1'b1;
                    cap_d   = 1'b0;
                    buf_d   = '0;
                end else begin
                    if (cap_q) buf_d = merged;
                    cap_d     = issue_q;
                    cap_idx_d = cnt_q;
                    if (issue_q && cnt_q != last_q) begin
                        cnt_d   = nxt;
                        mem_a_d = next_a;
                    end else begin
                        issue_d = 1'b0;
                    end
                    if (cap_q && cap_idx_q == last_q) begin
                        state_d = StDone;
                        cap_d   = 1'b0;
                        if (state_q == StInstRd) begin
                            inst_av_d = 1'b1;
                            inst_d    = merged;
                        end else begin
                            data_av_d = 1'b1;
                            rdata_d   = merged;
                        end
                    end
                end
            end
            StDataWr: begin
                if (cnt_q != last_q) begin
                    cnt_d      = nxt;
                    mem_a_d    = next_a;
                    mem_wr_d   = 1'b1;
                    mem_dout_d = wdata_q[{nxt, 3'b000} +: 8];
                end else begin
                    state_d   = StDone;
                    data_av_d = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            base_q     <= '0;
            last_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            issue_q    <= 1'b0;
            cap_q      <= 1'b0;
            cap_idx_q  <= '0;
            buf_q      <= '0;
            mem_a_q    <= '0;
            mem_wr_q   <= 1'b0;
            mem_dout_q <= '0;
            inst_av_q  <= 1'b0;
            inst_q     <= '0;
            data_av_q  <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            last_q     <= last_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            issue_q    <= issue_d;
            cap_q      <= cap_d;
            cap_idx_q  <= cap_idx_d;
            buf_q      <= buf_d;
            mem_a_q    <= mem_a_d;
            mem_wr_q   <= mem_wr_d;
            mem_dout_q <= mem_dout_d;
            inst_av_q  <= inst_av_d;
            inst_q     <= inst_d;
            data_av_q  <= data_av_d;
            rdata_q    <= rdata_d;
        end
    end

    assign inst_available = inst_av_q;
    assign inst_from_mem  = inst_q;
    assign data_available = data_av_q;
    assign data_rdata     = rdata_q;
    assign mem_a          = mem_a_q;
    assign mem_wr         = mem_wr_q;
    assign mem_dout       = mem_dout_q;

endmodule
